// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder sequencer driving an external full-adder cell
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             fa_i0,
    output logic             fa_i1,
    output logic             fa_ci,
    input  logic             fa_s,
    input  logic             fa_co,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             load;

    assign last = (cnt == LAST);
    assign load = start && (state == IDLE || state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Result registers update only on the final RUN edge so they stay stable mid-operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else if (load) begin
            a_sh   <= a;
            b_sh   <= b;
            sum_sh <= '0;
            carry  <= cin;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
            carry  <= fa_co;
            if (last) begin
                sum  <= {fa_s, sum_sh[WIDTH-1:1]};
                cout <= fa_co;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign busy  = (state == RUN);
    assign done  = (state == DONE);
    assign fa_i0 = busy & a_sh[0];
    assign fa_i1 = busy & b_sh[0];
    assign fa_ci = busy & carry;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - directed bench for serial_adder_ctrl with a behavioural full adder
module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             fa_i0;
    logic             fa_i1;
    logic             fa_ci;
    logic             fa_s;
    logic             fa_co;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int n_cmp;
    int n_err;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .fa_i0 (fa_i0),
        .fa_i1 (fa_i1),
        .fa_ci (fa_ci),
        .fa_s  (fa_s),
        .fa_co (fa_co),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    assign fa_s  = fa_i0 ^ fa_i1 ^ fa_ci;
    assign fa_co = (fa_i0 & fa_i1) | (fa_i0 & fa_ci) | (fa_i1 & fa_ci);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one operation and observe 15 cycles after the start-sampling edge.
    task automatic run_op(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic vc,
                          output int busy_cyc, output int done_k, output int done_cnt,
                          output int ci_low, output int fa_leak, output int sum_moved);
        logic [WIDTH-1:0] sum0;
        busy_cyc = 0; done_k = -1; done_cnt = 0; ci_low = 0; fa_leak = 0; sum_moved = 0;
        @(negedge clk);
        sum0 = sum;
        start = 1'b1; a = va; b = vb; cin = vc;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 15; k++) begin
            if (busy) begin
                busy_cyc++;
                if (!fa_ci) ci_low++;
                if (sum !== sum0) sum_moved++;
            end else if (fa_i0 || fa_i1 || fa_ci) begin
                fa_leak++;
            end
            if (done) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, sum, cout, fa_i0, fa_i1, fa_ci} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b fa=%b%b%b, want all 0",
                     busy, done, sum, cout, fa_i0, fa_i1, fa_ci);
        end
        rst_n = 1'b1; start = 1'b1; a = 8'h01; b = 8'h01;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL start_after_reset: got busy=%b, want 1", busy);
        end
        repeat (12) @(posedge clk);
        #1;
        n_cmp++;
        if (sum !== 8'h02 || cout !== 1'b0) begin
            n_err++;
            $display("FAIL first_op_result: got sum=%h cout=%b, want 02 0", sum, cout);
        end
    endtask

    task automatic test_basic;
        int bc, dk, dc, cl, fl, sm;
        run_op(8'h3C, 8'h0F, 1'b0, bc, dk, dc, cl, fl, sm);
        n_cmp++;
        if (sum !== 8'h4B || cout !== 1'b0) begin
            n_err++;
            $display("FAIL basic_result: got sum=%h cout=%b, want 4B 0", sum, cout);
        end
        n_cmp++;
        if (dk !== 8 || dc !== 1) begin
            n_err++;
            $display("FAIL basic_done: got done at cycle %0d x%0d, want cycle 8 x1", dk, dc);
        end
        n_cmp++;
        if (sm !== 0 || fl !== 0) begin
            n_err++;
            $display("FAIL basic_hold: got sum_moved=%0d fa_leak=%0d, want 0 0", sm, fl);
        end
    endtask

    task automatic test_carry_out;
        int bc, dk, dc, cl, fl, sm;
        run_op(8'hFF, 8'h01, 1'b0, bc, dk, dc, cl, fl, sm);
        n_cmp++;
        if (sum !== 8'h00 || cout !== 1'b1) begin
            n_err++;
            $display("FAIL carry_result: got sum=%h cout=%b, want 00 1", sum, cout);
        end
        n_cmp++;
        if (bc !== 8) begin
            n_err++;
            $display("FAIL carry_busy_len: got %0d busy cycles, want 8", bc);
        end
    endtask

    task automatic test_cin;
        int bc, dk, dc, cl, fl, sm;
        run_op(8'hA5, 8'h5A, 1'b1, bc, dk, dc, cl, fl, sm);
        n_cmp++;
        if (sum !== 8'h00 || cout !== 1'b1) begin
            n_err++;
            $display("FAIL cin_result: got sum=%h cout=%b, want 00 1", sum, cout);
        end
        n_cmp++;
        if (cl !== 0 || bc !== 8) begin
            n_err++;
            $display("FAIL cin_fa_ci: got %0d low cycles of %0d, want 0 of 8", cl, bc);
        end
    endtask

    task automatic test_start_in_run;
        int dk, dc;
        dk = -1; dc = 0;
        @(negedge clk);
        start = 1'b1; a = 8'h22; b = 8'h33; cin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 15; k++) begin
            if (k == 2) begin
                start = 1'b1; a = 8'h11; b = 8'h00;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                dc++;
                if (dk < 0) dk = k;
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (sum !== 8'h55 || cout !== 1'b0) begin
            n_err++;
            $display("FAIL ignore_start_result: got sum=%h cout=%b, want 55 0", sum, cout);
        end
        n_cmp++;
        if (dk !== 8 || dc !== 1) begin
            n_err++;
            $display("FAIL ignore_start_done: got done at %0d x%0d, want 8 x1", dk, dc);
        end
    endtask

    task automatic test_back_to_back;
        int d1, d2, dc;
        logic [WIDTH-1:0] s1;
        d1 = -1; d2 = -1; dc = 0; s1 = '0;
        @(negedge clk);
        start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 25; k++) begin
            start = 1'b0;
            if (done) begin
                dc++;
                if (d1 < 0) begin
                    d1 = k; s1 = sum;
                    start = 1'b1; a = 8'h01; b = 8'h02; cin = 1'b0;
                end else if (d2 < 0) begin
                    d2 = k;
                end
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        n_cmp++;
        if (d1 !== 8 || s1 !== 8'h30) begin
            n_err++;
            $display("FAIL b2b_first: got done at %0d sum=%h, want 8 30", d1, s1);
        end
        n_cmp++;
        if (d2 !== 17 || dc !== 2) begin
            n_err++;
            $display("FAIL b2b_second_done: got done at %0d x%0d, want 17 x2", d2, dc);
        end
        n_cmp++;
        if (sum !== 8'h03 || cout !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_second_result: got sum=%h cout=%b, want 03 0", sum, cout);
        end
    endtask

    task automatic test_reset_mid_run;
        int dc, bc, dk, cl, fl, sm;
        dc = 0;
        @(negedge clk);
        start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, sum, cout, fa_i0, fa_i1, fa_ci} !== '0) begin
            n_err++;
            $display("FAIL async_reset: got busy=%b done=%b sum=%h cout=%b fa=%b%b%b, want all 0",
                     busy, done, sum, cout, fa_i0, fa_i1, fa_ci);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done || busy) dc++;
        end
        n_cmp++;
        if (dc !== 0) begin
            n_err++;
            $display("FAIL abort_no_done: got %0d active cycles after abort, want 0", dc);
        end
        run_op(8'h12, 8'h34, 1'b1, bc, dk, dc, cl, fl, sm);
        n_cmp++;
        if (sum !== 8'h47 || cout !== 1'b0 || dk !== 8) begin
            n_err++;
            $display("FAIL post_reset_op: got sum=%h cout=%b done_at=%0d, want 47 0 8", sum, cout, dk);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_carry_out();
        test_cin();
        test_start_in_run();
        test_back_to_back();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
